// File: rtl/on_chip_pixel_master_if.sv
// rtl/on_chip_pixel_master_if.sv - pixel stream, readback stream and memory bus bundle.
interface on_chip_pixel_master_if #(
  parameter int ADDR_W = 15
) ();
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              pix_eof;
  logic              pix_ready;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              rd_ready;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;

  modport master (
    input  pix_valid, pix_data, pix_eof, rd_ready, avm_readdata,
    output pix_ready, rd_valid, rd_data,
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata
  );

  modport slave (
    output pix_valid, pix_data, pix_eof, rd_ready, avm_readdata,
    input  pix_ready, rd_valid, rd_data,
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata
  );
endinterface

// File: rtl/on_chip_pixel_master.sv
// rtl/on_chip_pixel_master.sv - packs pixel bytes into 32-bit memory writes and reads words back.
module on_chip_pixel_master #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 25600
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_words,
  output logic              busy,
  output logic              done,
  on_chip_pixel_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, PACK, WR, RD_ADDR, RD_WAIT, RD_HOLD, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_inc;
  logic [ADDR_W:0]   remain;
  logic [31:0]       wdata, rdata;
  logic [3:0]        mask;
  logic [1:0]        idx;
  logic              eof_seen;
  logic              pix_fire, rd_fire, last_word;

  assign pix_fire  = (state == PACK) && bus.pix_valid;
  assign rd_fire   = (state == RD_HOLD) && bus.rd_ready;
  assign last_word = (remain == (ADDR_W + 1)'(1));
  assign addr_inc  = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_start) state_nx = cmd_read ? RD_ADDR : PACK;
      PACK:    if (pix_fire && (idx == 2'd3 || bus.pix_eof)) state_nx = WR;
      WR:      state_nx = (last_word || eof_seen) ? FIN : PACK;
      RD_ADDR: state_nx = RD_WAIT;
      RD_WAIT: state_nx = RD_HOLD;
      RD_HOLD: if (rd_fire) state_nx = last_word ? FIN : RD_ADDR;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.pix_ready      = (state == PACK);
    bus.rd_valid       = (state == RD_HOLD);
    bus.avm_chipselect = (state == WR) || (state == RD_ADDR);
    bus.avm_write      = (state == WR);
    bus.avm_byteenable = 4'h0;
    if (state == WR)           bus.avm_byteenable = mask;
    else if (state == RD_ADDR) bus.avm_byteenable = 4'hF;
    busy = (state != IDLE);
    done = (state == FIN);
  end

  assign bus.avm_address   = addr;
  assign bus.avm_writedata = wdata;
  assign bus.rd_data       = rdata;

  // Datapath; everything clears on reset so an interrupted word is simply dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr     <= '0;
      remain   <= '0;
      wdata    <= '0;
      rdata    <= '0;
      mask     <= '0;
      idx      <= '0;
      eof_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_start) begin
          addr     <= cmd_base;
          remain   <= (cmd_words == '0) ? DEPTH_CNT : {1'b0, cmd_words};
          wdata    <= '0;
          mask     <= '0;
          idx      <= '0;
          eof_seen <= 1'b0;
        end
        PACK: if (pix_fire) begin
          wdata[{idx, 3'b000} +: 8] <= bus.pix_data;
          mask[idx]                 <= 1'b1;
          idx                       <= idx + 2'd1;
          eof_seen                  <= bus.pix_eof;
        end
        WR: begin
          addr   <= addr_inc;
          remain <= remain - (ADDR_W + 1)'(1);
          wdata  <= '0;
          mask   <= '0;
          idx    <= '0;
        end
        RD_WAIT: rdata <= bus.avm_readdata;
        RD_HOLD: if (rd_fire) begin
          addr   <= addr_inc;
          remain <= remain - (ADDR_W + 1)'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_on_chip_pixel_master.sv
// tb/tb_on_chip_pixel_master.sv - scoreboard bench for on_chip_pixel_master.
module tb_on_chip_pixel_master;
  localparam int ADDR_W = 15;
  localparam int DEPTH  = 25600;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_start = 1'b0;
  logic              cmd_read = 1'b0;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [ADDR_W-1:0] cmd_words = '0;
  logic              busy, done;

  on_chip_pixel_master_if #(.ADDR_W(ADDR_W)) bus ();

  on_chip_pixel_master #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_read(cmd_read),
    .cmd_base(cmd_base), .cmd_words(cmd_words), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  wr_t         exp_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  int          acc_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Memory model: one-cycle read latency, byte-lane writes.
  always @(posedge clk) begin
    if (bus.avm_chipselect && bus.avm_write) begin
      for (int b = 0; b < 4; b++)
        if (bus.avm_byteenable[b]) mem[bus.avm_address][b*8 +: 8] <= bus.avm_writedata[b*8 +: 8];
    end
    if (bus.avm_chipselect && !bus.avm_write) bus.avm_readdata <= mem[bus.avm_address];
  end

  always @(negedge clk) begin
    if (bus.avm_chipselect) acc_count++;
    if (bus.avm_chipselect && bus.avm_write) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {17'b0, bus.avm_address}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {17'b0, bus.avm_address}, {17'b0, e.addr});
        check("wr_be", {28'b0, bus.avm_byteenable}, {28'b0, e.be});
        check("wr_data", bus.avm_writedata & lanes(e.be), e.data & lanes(e.be));
      end
    end
  end

  task automatic start_cmd(input logic rd, input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] n);
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_read = rd; cmd_base = base; cmd_words = n;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic eof);
    int t = 0;
    bus.pix_valid = 1'b1; bus.pix_data = d; bus.pix_eof = eof;
    @(negedge clk);
    while (!bus.pix_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("pix_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0; bus.pix_eof = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!done && t < 200) begin @(negedge clk); t++; end
    check("done_seen", {31'b0, done}, 32'd1);
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd0);
    check("busy_after", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_outs"}, {25'b0, bus.pix_ready, bus.rd_valid, bus.avm_chipselect, bus.avm_write,
                           busy, done, |bus.avm_byteenable}, 32'd0);
    check({tag, "_addr"}, {17'b0, bus.avm_address}, 32'd0);
    check({tag, "_wdata"}, bus.avm_writedata, 32'd0);
    check({tag, "_rdata"}, bus.rd_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    logic [31:0] e;
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.pix_eof = 1'b0; bus.rd_ready = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Two full words from base 0
    exp_q.push_back('{addr: 15'd0, data: 32'h4433_2211, be: 4'hF});
    exp_q.push_back('{addr: 15'd1, data: 32'h8877_6655, be: 4'hF});
    start_cmd(1'b0, 15'd0, 15'd2);
    check("busy_started", {31'b0, busy}, 32'd1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11), 1'b0);
    wait_done();
    check("q_empty_a", exp_q.size(), 32'd0);

    // Partial word terminated by pix_eof
    exp_q.push_back('{addr: 15'd100, data: 32'h00CC_BBAA, be: 4'h7});
    start_cmd(1'b0, 15'd100, 15'd4);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    wait_done();
    check("q_empty_b", exp_q.size(), 32'd0);
    bus.pix_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_pix_after_eof", {31'b0, bus.pix_ready}, 32'd0);
    end
    bus.pix_valid = 1'b0;

    // Address wrap at the top of memory
    exp_q.push_back('{addr: 15'd25599, data: 32'h0403_0201, be: 4'hF});
    exp_q.push_back('{addr: 15'd0,     data: 32'h0807_0605, be: 4'hF});
    start_cmd(1'b0, 15'd25599, 15'd2);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    wait_done();
    check("q_empty_c", exp_q.size(), 32'd0);

    // Readback with a stall on the second word; stray pixels must be ignored
    mem[10] = 32'hA5A5_0010; mem[11] = 32'h5A5A_0011; mem[12] = 32'hDEAD_0012;
    for (int i = 10; i <= 12; i++) rd_q.push_back(mem[i]);
    saved = wr_count;
    bus.pix_valid = 1'b1; bus.pix_eof = 1'b1;
    start_cmd(1'b1, 15'd10, 15'd3);
    for (int k = 0; k < 3; k++) begin
      int t = 0;
      @(negedge clk);
      while (!bus.rd_valid && t < 50) begin @(negedge clk); t++; end
      check("rd_valid_seen", {31'b0, bus.rd_valid}, 32'd1);
      e = rd_q.pop_front();
      if (k == 1) begin
        repeat (4) begin
          check("rd_stall_data", bus.rd_data, e);
          check("rd_stall_valid", {31'b0, bus.rd_valid}, 32'd1);
          @(negedge clk);
        end
      end
      check("rd_data", bus.rd_data, e);
      check("rd_no_pix", {31'b0, bus.pix_ready}, 32'd0);
      bus.rd_ready = 1'b1;
      @(posedge clk); #1;
      bus.rd_ready = 1'b0;
    end
    wait_done();
    bus.pix_valid = 1'b0; bus.pix_eof = 1'b0;
    check("rd_no_writes", wr_count, saved);

    // Reset during the write of the second word
    exp_q.push_back('{addr: 15'd50, data: 32'h1312_1110, be: 4'hF});
    mem[51] = 32'hCAFE_F00D;
    start_cmd(1'b0, 15'd50, 15'd4);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    saved = acc_count;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_access", acc_count, saved);
    check("post_reset_busy", {31'b0, busy}, 32'd0);
    check("mem51_kept", mem[51], 32'hCAFE_F00D);
    check("q_empty_d", exp_q.size(), 32'd0);

    // cmd_start while busy is ignored
    exp_q.push_back('{addr: 15'd200, data: 32'hF4F3_F2F1, be: 4'hF});
    saved = wr_count;
    start_cmd(1'b0, 15'd200, 15'd1);
    start_cmd(1'b1, 15'd300, 15'd5);
    for (int i = 1; i <= 4; i++) send_byte(8'(8'hF0 + i), 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    check("busy_cmd_writes", wr_count - saved, 32'd1);
    check("busy_cmd_no_read", {30'b0, bus.rd_valid, busy}, 32'd0);
    check("q_empty_e", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
